// File: rtl/serial_add_seq.sv
// Bit-serial addition sequencer: streams an operand pair LSB-first through an
// external full-adder cell and collects the sum. Optional overflow flag: SERIAL_ADD_OVF_EN.
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;

`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The full-adder drive is kept apart from the next-state logic so the
  // external fa_sum/fa_carry return path never looks like a loop through it.
  assign run       = (state_q == S_RUN);
  assign fa_a      = run & a_sh_q[0];
  assign fa_b      = run & b_sh_q[0];
  assign fa_c      = run & carry_q;
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
`ifdef SERIAL_ADD_OVF_EN
          // On the MSB, carry_q is the carry into the sign bit.
          ovf_d   = carry_q ^ fa_carry;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a behavioural full adder in the loop.
module tb_serial_add_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         fa_a;
  logic         fa_b;
  logic         fa_c;
  logic         fa_sum;
  logic         fa_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_c     (fa_c),
    .fa_sum   (fa_sum),
    .fa_carry (fa_carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (sum !== 4'b0000) begin n_err++; $display("FAIL reset sum: got %b want 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset cout: got %b want 0", cout); end
    n_cmp++; if ({fa_a, fa_b, fa_c} !== 3'b000) begin n_err++; $display("FAIL reset fa_abc: got %b want 000", {fa_a, fa_b, fa_c}); end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset ovf: got %b want 0", ovf); end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed vectors: a, b, cin -> sum, cout, signed overflow.
  task automatic test_basic();
    logic [W-1:0] va [4] = '{4'b0101, 4'b1111, 4'b0000, 4'b0111};
    logic [W-1:0] vb [4] = '{4'b0011, 4'b0001, 4'b0000, 4'b1001};
    logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] vs [4] = '{4'b1000, 4'b0000, 4'b0001, 4'b0001};
    logic         vo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic         vv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int           lat;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic%0d idle in_ready: got %b want 1", i, in_ready); end
      a = va[i]; b = vb[i]; cin = vc[i];
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if ({fa_a, fa_b, fa_c} !== {va[i][0], vb[i][0], vc[i]})
        begin n_err++; $display("FAIL basic%0d first fa_abc: got %b want %b", i, {fa_a, fa_b, fa_c}, {va[i][0], vb[i][0], vc[i]}); end
      lat = 0;
      while (!out_valid && lat < 3 * W) begin
        @(posedge clk); #1;
        lat++;
      end
      n_cmp++; if (lat !== W) begin n_err++; $display("FAIL basic%0d latency: got %0d want %0d", i, lat, W); end
      n_cmp++; if (sum !== vs[i]) begin n_err++; $display("FAIL basic%0d sum: got %b want %b", i, sum, vs[i]); end
      n_cmp++; if (cout !== vo[i]) begin n_err++; $display("FAIL basic%0d cout: got %b want %b", i, cout, vo[i]); end
`ifdef SERIAL_ADD_OVF_EN
      n_cmp++; if (ovf !== vv[i]) begin n_err++; $display("FAIL basic%0d ovf: got %b want %b", i, ovf, vv[i]); end
`endif
      n_cmp++; if ({fa_a, fa_b, fa_c} !== 3'b000) begin n_err++; $display("FAIL basic%0d done fa_abc: got %b want 000", i, {fa_a, fa_b, fa_c}); end
      @(posedge clk); #1;
      n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL basic%0d post-handshake rdy/vld: got %b want 10", i, {in_ready, out_valid}); end
      n_cmp++; if (sum !== vs[i]) begin n_err++; $display("FAIL basic%0d sum hold: got %b want %b", i, sum, vs[i]); end
      if (vv[i] === 1'bx) $display("unreachable");
    end
  endtask

  // 0110 + 0111 = 1101, no carry-out, signed overflow; consumer stalls 3 cycles.
  task automatic test_backpressure();
    int wait_cyc;
    @(posedge clk); #1;
    a = 4'b0110; b = 4'b0111; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    a = 4'b1111; b = 4'b1111; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 3 * W) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp reach done: got out_valid %b want 1", out_valid); end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp%0d out_valid: got %b want 1", k, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp%0d in_ready: got %b want 0", k, in_ready); end
      n_cmp++; if ({cout, sum} !== 5'b0_1101) begin n_err++; $display("FAIL bp%0d cout/sum: got %b want 01101", k, {cout, sum}); end
`ifdef SERIAL_ADD_OVF_EN
      n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp%0d ovf: got %b want 1", k, ovf); end
`endif
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL bp release rdy/vld: got %b want 10", {in_ready, out_valid}); end
    n_cmp++; if ({cout, sum} !== 5'b0_1101) begin n_err++; $display("FAIL bp release cout/sum: got %b want 01101", {cout, sum}); end
  endtask

  // Reset during the second RUN cycle of 1010+0110, then 0001+0001 = 0010.
  task automatic test_reset_mid_run();
    int lat;
    @(posedge clk); #1;
    a = 4'b1010; b = 4'b0110; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL rst-run rdy/vld: got %b want 10", {in_ready, out_valid}); end
    n_cmp++; if ({cout, sum} !== 5'b0_0000) begin n_err++; $display("FAIL rst-run cout/sum: got %b want 00000", {cout, sum}); end
    n_cmp++; if ({fa_a, fa_b, fa_c} !== 3'b000) begin n_err++; $display("FAIL rst-run fa_abc: got %b want 000", {fa_a, fa_b, fa_c}); end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst-run ovf: got %b want 0", ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a = 4'b0001; b = 4'b0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 3 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== W) begin n_err++; $display("FAIL rst-run next latency: got %0d want %0d", lat, W); end
    n_cmp++; if ({cout, sum} !== 5'b0_0010) begin n_err++; $display("FAIL rst-run next cout/sum: got %b want 00010", {cout, sum}); end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst-run next ovf: got %b want 0", ovf); end
`endif
    @(posedge clk); #1;
  endtask

  // in_valid and out_ready held high; random operands scored against a+b+cin.
  task automatic test_back_to_back();
    localparam int N_OPS = 12;
    logic [W+1:0] exp_q [$];
    logic [W+1:0] exp_v;
    logic [W:0]   full;
    logic         acc;
    int           last_acc;
    int           n_push;
    int           n_done;
    last_acc = -1;
    n_push   = 0;
    n_done   = 0;
    @(posedge clk); #1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 * N_OPS && n_done < N_OPS; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b2b unexpected result: got %b with empty scoreboard", {cout, sum});
        end else begin
          exp_v = exp_q.pop_front();
          n_cmp++; if ({cout, sum} !== exp_v[W:0]) begin n_err++; $display("FAIL b2b op%0d cout/sum: got %b want %b", n_done, {cout, sum}, exp_v[W:0]); end
`ifdef SERIAL_ADD_OVF_EN
          n_cmp++; if (ovf !== exp_v[W+1]) begin n_err++; $display("FAIL b2b op%0d ovf: got %b want %b", n_done, ovf, exp_v[W+1]); end
`endif
        end
        n_done++;
      end
      if (acc) begin
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        exp_v = {(a[W-1] == b[W-1]) && (full[W-1] != a[W-1]), full};
        exp_q.push_back(exp_v);
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc !== W + 2) begin n_err++; $display("FAIL b2b accept interval: got %0d want %0d", cyc - last_acc, W + 2); end
        end
        last_acc = cyc;
        n_push++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (n_push == N_OPS) in_valid = 1'b0;
        else begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (n_done !== N_OPS) begin n_err++; $display("FAIL b2b results seen: got %0d want %0d", n_done, N_OPS); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial addition sequencer for the adder datapath. Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake. Streams the operands LSB-first into an external single-bit full adder and collects its sum and carry outputs. Shifts the sum bits back into a result register and presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits directly upstream and downstream of the gate-level full adder cell: it drives that cell's a/b/c inputs and consumes its sum/carry outputs.

## Interface
- WIDTH, default 4: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; one clock; all state clears immediately on assertion.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, sampled on acceptance.
- b  input  WIDTH  operand B, sampled on acceptance.
- cin  input  1  carry-in, sampled on acceptance.
- fa_a  output  1  full-adder input a: current LSB of A shift register.
- fa_b  output  1  full-adder input b: current LSB of B shift register.
- fa_c  output  1  full-adder input c: registered running carry.
- fa_sum  input  1  full-adder sum output; combinational from fa_a/fa_b/fa_c.
- fa_carry  input  1  full-adder carry output; combinational from fa_a/fa_b/fa_c.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a_sh<=a, b_sh<=b, carry<=cin, bit_cnt<=0. Go to RUN.
- RUN:
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry.
  - Each edge: a_sh and b_sh shift right by 1 with zero fill.
  - The sum register shifts right, with fa_sum entering at bit WIDTH-1.
  - carry<=fa_carry; bit_cnt increments.
  - On the edge where bit_cnt==WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; sum holds the full result; cout=carry.
  - On out_ready, go to IDLE. sum and cout keep their values until the next acceptance.
- fa_a, fa_b and fa_c are 0 outside RUN.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Result equals (a+b+cin) mod 2^WIDTH. cout is bit WIDTH of the true sum.
- bit_cnt width is $clog2(WIDTH). No wrap occurs because the transition to DONE happens at WIDTH-1.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, fa_a=fa_b=fa_c=0, ovf=0. Internal registers are 0.
- Accept edge E0. RUN covers cycles 1..WIDTH. out_valid rises after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Output handshake at edge Ed. in_ready is high in the following cycle.
- Minimum period per operation is WIDTH+2 cycles when out_ready is held high.
- The full-adder path is combinational within one cycle: fa_* out, then fa_sum/fa_carry back in, then registers.
- Reset mid-RUN or in DONE: the operation is abandoned and no out_valid is produced. After release the block is in IDLE with all outputs at reset values.
- Backpressure: while out_valid=1 and out_ready=0, sum, cout and ovf are stable.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - An extra 1-bit register captures carry-into-MSB (fa_c during the last RUN cycle).
  - ovf is registered as carry_into_msb ^ fa_carry on the final RUN edge.
  - ovf is valid with out_valid and holds like sum.
- SERIAL_ADD_OVF_EN not defined: the ovf port and its logic are absent.

## Test plan
- WIDTH=4, a=0101, b=0011, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=1000, cout=0, ovf=1.
- a=1111, b=0001, cin=0 → sum=0000, cout=1, ovf=0. a=0000, b=0000, cin=1 → sum=0001, cout=0.
- out_ready held low 3 cycles in DONE → out_valid, sum and cout are stable; in_ready stays 0; in_valid pulses during RUN/DONE are ignored.
- rst_n asserted on the 2nd RUN cycle of a=1010, b=0110 → outputs immediately at reset values. The next accept of 0001+0001 yields sum=0010 with no stale carry.
- Back-to-back with in_valid and out_ready tied high → exactly one accept every WIDTH+2 cycles. Run a random sweep with a scoreboard against a+b+cin.
